mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multi-cycle MIPS multiply/divide unit that sits directly downstream of the register file. It consumes the two read-data operands and executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles. Results go into architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. Busy stalls the pipeline's issue logic while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.
ITER, 32, iteration count; must equal WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
Start  input  1  request a new operation; sampled only when Busy=0
Op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
Operand_A  input  32  rs value (multiplicand / dividend), fed from Read_Data_1
Operand_B  input  32  rt value (multiplier / divisor), fed from Read_Data_2
Write_HI  input  1  MTHI strobe
Write_LO  input  1  MTLO strobe
Write_Data  input  32  MTHI/MTLO data
HI  output  32  HI register (product high word / remainder)
LO  output  32  LO register (product low word / quotient)
Busy  output  1  operation in flight
Done  output  1  one-cycle pulse; HI/LO updated in the same cycle

Behaviour:
- Reset: synchronous and active-high.
  - Reset sets HI=0, LO=0, Busy=0, Done=0 and the state to IDLE.
  - Reset mid-operation abandons the operation: no Done, and HI/LO are cleared.
- States: IDLE, CALC, FIX.
- IDLE with Start=1 at edge k: accept the operation.
  - Latch Op, the operand magnitudes, the result sign and the remainder sign. Clear the 64-bit accumulator and the 5-bit counter.
  - Go to CALC. Busy=1 after edge k.
- CALC, edges k+1..k+32: one iteration per edge; the counter increments.
  - Multiply is shift-add on magnitudes.
  - Divide is restoring shift-subtract on magnitudes.
  - After the 32nd iteration (counter wraps 31->0), go to FIX.
- FIX, edge k+33:
  - Apply sign correction and write HI/LO.
  - Done=1 for exactly the cycle after edge k+33. Busy=0 from that same cycle. Return to IDLE.
- Total: 33 Busy cycles, Done 33 edges after acceptance.
- Signed rules:
  - MULT negates the 64-bit product if sign(A) xor sign(B).
  - DIV negates the quotient if sign(A) xor sign(B), and gives the remainder the sign of the dividend.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. This falls out of the magnitude path with no special case.
- Divide by zero (DIV/DIVU, Operand_B=0), detected at acceptance:
  - Skip CALC and go IDLE->FIX.
  - Done after edge k+1, with HI=Operand_A (raw) and LO=0xFFFFFFFF.
- MTHI/MTLO:
  - In IDLE, Write_HI/Write_LO loads Write_Data into HI/LO at the next edge.
  - Both strobes asserted together load both registers.
  - Strobes are ignored while Busy=1 or in the FIX cycle.
- Simultaneous events:
  - Start and Write_HI/LO in the same IDLE cycle: Start wins and the write is dropped.
  - Start while Busy=1 is ignored; no queueing.
  - Start in the Done cycle is accepted, because state is IDLE.
- HI/LO hold their value at all times except at the FIX edge, an accepted MTHI/MTLO edge, or reset.
- Operand inputs are don't-care except at the acceptance edge.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - MULT/MULTU with Operand_A=0 or Operand_B=0 takes the IDLE->FIX path and sets HI=LO=0, Done after edge k+1.
  - DIV/DIVU with Operand_A=0 and Operand_B≠0 takes the same path and sets HI=LO=0, Done after edge k+1.
- Undefined: these cases take the full 33-edge path and give identical HI/LO values. Only divide-by-zero short-circuits.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Busy high 33 cycles; Done exactly 33 edges after acceptance, for one cycle.
2. MULT A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
3. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002.
4. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF, Done after edge k+1.
5. Start a MULTU and, while Busy, pulse Start (new operands) and Write_HI=0xDEADBEEF -> both ignored; the original result is delivered. Start another operation and assert rst at iteration 10 -> next cycle Busy=0, HI=LO=0, and no Done follows.
6. IDLE: Write_HI with Write_Data=0xDEADBEEF, then Write_LO with 0xCAFEF00D -> HI=0xDEADBEEF, LO=0xCAFEF00D one edge after each strobe. With MDU_EARLY_OUT_EN: MULT A=0, B=5 -> Done after edge k+1, HI=LO=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MDU_EARLY_OUT_EN: zero-operand multiply/divide skips the iteration phase.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Write_HI,
    input  logic             Write_LO,
    input  logic [WIDTH-1:0] Write_Data,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               bypass;
    logic [WIDTH-1:0]   mag_op;
    logic [2*WIDTH-1:0] acc;
    logic [4:0]         cnt;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               div_zero;
    logic               early;

    assign op_signed = ~Op[0];
    assign a_neg     = op_signed & Operand_A[WIDTH-1];
    assign b_neg     = op_signed & Operand_B[WIDTH-1];
    assign mag_a_in  = a_neg ? (~Operand_A + 1'b1) : Operand_A;
    assign mag_b_in  = b_neg ? (~Operand_B + 1'b1) : Operand_B;
    assign div_zero  = Op[1] & (Operand_B == '0);

`ifdef MDU_EARLY_OUT_EN
    assign early = Op[1] ? (Operand_A == '0) && (Operand_B != '0)
                         : (Operand_A == '0) || (Operand_B == '0);
`else
    assign early = 1'b0;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     sub_diff;
    logic               sub_ok;

    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_op};
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign sub_diff = rem_sh - {1'b0, mag_op};
    assign sub_ok   = ~sub_diff[WIDTH];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

    assign Busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            HI      <= '0;
            LO      <= '0;
            Done    <= 1'b0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bypass  <= 1'b0;
            mag_op  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        is_div  <= Op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        mag_op  <= Op[1] ? mag_b_in : mag_a_in;
                        cnt     <= '0;
                        if (div_zero || early) begin
                            // Short path: final HI/LO are preloaded and FIX passes them through.
                            bypass <= 1'b1;
                            acc    <= div_zero ? {Operand_A, {WIDTH{1'b1}}} : '0;
                            state  <= S_FIX;
                        end else begin
                            bypass <= 1'b0;
                            acc    <= {{WIDTH{1'b0}}, (Op[1] ? mag_a_in : mag_b_in)};
                            state  <= S_CALC;
                        end
                    end else begin
                        if (Write_HI) HI <= Write_Data;
                        if (Write_LO) LO <= Write_Data;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc <= sub_ok ? {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                      : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= acc[0] ? {add_sum, acc[WIDTH-1:1]}
                                      : {1'b0, acc[2*WIDTH-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (bypass) begin
                        HI <= acc[2*WIDTH-1:WIDTH];
                        LO <= acc[WIDTH-1:0];
                    end else if (is_div) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle, plus directed
// literal checks. Honours MDU_EARLY_OUT_EN for the expected latency of zero-operand ops.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Write_HI;
    logic        Write_LO;
    logic [31:0] Write_Data;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op),
        .Operand_A(Operand_A), .Operand_B(Operand_B),
        .Write_HI(Write_HI), .Write_LO(Write_LO), .Write_Data(Write_Data),
        .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[1] && b == 0) return 1;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1] && (a == 0 || b == 0)) return 1;
        if (op[1] && a == 0) return 1;
`endif
        return 33;
    endfunction

    // Reference model: edges remaining until the result lands, plus architectural HI/LO.
    int          m_left  = 0;
    logic        m_valid = 1'b0;
    logic        m_done  = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [63:0] m_pend  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                    m_done = 1'b1;
                end
            end else if (Start) begin
                m_pend = ref_result(Op, Operand_A, Operand_B);
                m_left = ref_latency(Op, Operand_A, Operand_B);
            end else begin
                if (Write_HI) m_hi = Write_Data;
                if (Write_LO) m_lo = Write_Data;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
            chk("model_done", {31'd0, Done}, {31'd0, m_done});
            chk("model_hi", HI, m_hi);
            chk("model_lo", LO, m_lo);
        end
    end

    task automatic idle_inputs();
        Start = 1'b0; Op = 2'b00; Operand_A = '0; Operand_B = '0;
        Write_HI = 1'b0; Write_LO = 1'b0; Write_Data = '0;
    endtask

    // Issue one op at the current negedge and check latency, busy span and result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
        int n, busy_cnt;
        bit seen;
        Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
        @(negedge clk);
        Start = 1'b0;
        n = 0; busy_cnt = 0; seen = 0;
        while (n < 40) begin
            if (Done) begin seen = 1; break; end
            if (Busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        chk({name, "_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_busy"}, busy_cnt, exp_lat);
        chk({name, "_hi"}, HI, exp_hi);
        chk({name, "_lo"}, LO, exp_lo);
        @(negedge clk);
        chk({name, "_pulse"}, {31'd0, Done}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] r;
        int n;
        bit seen;

        // Pin the model against hand-computed values.
        r = ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("pin_multu", r[31:0], 32'h00000001);
        chk("pin_multu_hi", r[63:32], 32'hFFFFFFFE);
        r = ref_result(2'b00, 32'hFFFFFFFD, 32'h7);
        chk("pin_mult", r[31:0], 32'hFFFFFFEB);
        r = ref_result(2'b10, 32'hFFFFFFF9, 32'h2);
        chk("pin_div", r[63:32], 32'hFFFFFFFF);
        r = ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF);
        chk("pin_div_ovf", r[31:0], 32'h80000000);

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run_op("divu_zero", 2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1);

        // Start and MTHI while busy must be ignored.
        Start = 1'b1; Op = 2'b01; Operand_A = 32'd1000; Operand_B = 32'd3000;
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        Start = 1'b1; Op = 2'b01; Operand_A = 32'd5; Operand_B = 32'd5;
        Write_HI = 1'b1; Write_Data = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        n = 0; seen = 0;
        while (n < 40) begin
            if (Done) begin seen = 1; break; end
            @(negedge clk);
            n++;
        end
        chk("ignore_seen", {31'd0, seen}, 32'd1);
        chk("ignore_lat", n, 28);
        chk("ignore_hi", HI, 32'h0);
        chk("ignore_lo", LO, 32'd3000000);
        @(negedge clk);

        // Reset at iteration 10 abandons the op.
        Start = 1'b1; Op = 2'b00; Operand_A = 32'd12345; Operand_B = 32'd678;
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen = 1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        // MTHI then MTLO in IDLE.
        Write_HI = 1'b1; Write_Data = 32'hDEADBEEF;
        @(negedge clk);
        Write_HI = 1'b0;
        chk("mthi", HI, 32'hDEADBEEF);
        Write_LO = 1'b1; Write_Data = 32'hCAFEF00D;
        @(negedge clk);
        Write_LO = 1'b0;
        chk("mtlo", LO, 32'hCAFEF00D);
        chk("mtlo_hi_hold", HI, 32'hDEADBEEF);

        // Start beats a simultaneous MTLO.
        Write_LO = 1'b1; Write_Data = 32'h11111111;
        run_op("start_wins", 2'b11, 32'd50, 32'd8, 32'd2, 32'd6, 33);
        Write_LO = 1'b0;

`ifdef MDU_EARLY_OUT_EN
        run_op("mult_zero", 2'b00, 32'h0, 32'd5, 32'h0, 32'h0, 1);
`else
        run_op("mult_zero", 2'b00, 32'h0, 32'd5, 32'h0, 32'h0, 33);
`endif

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            Start      = ($urandom_range(0, 3) == 0);
            Op         = 2'($urandom_range(0, 3));
            Operand_A  = pick_operand();
            Operand_B  = pick_operand();
            Write_HI   = ($urandom_range(0, 3) == 0);
            Write_LO   = ($urandom_range(0, 3) == 0);
            Write_Data = $urandom;
            rst        = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        idle_inputs();
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
